// File: rtl/acc_cpu_param.sv
// acc_cpu_param: parametrised accumulator CPU core.
// Unified RAM, 5-phase fetch/execute FSM, memory-mapped output register.
module acc_cpu_param #(
  parameter int ADDR_W = 5,
  parameter int OUT_ADDR = 2**ADDR_W - 1,
  localparam int WORD_W = 3 + ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WORD_W-1:0] load_data,
  input  logic              start,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [WORD_W-1:0] ac,
  output logic              cf,
  output logic              zf,
  output logic [WORD_W-1:0] out_port,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WORD_W-1:0] dbg_data
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(OUT_ADDR);

  typedef enum logic [2:0] {
    IDLE, F1, F2, F3, E1, E2
  } state_t;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_LDA = 3'd1,
    OP_ADD = 3'd2,
    OP_STO = 3'd3,
    OP_SUB = 3'd4,
    OP_JNZ = 3'd5,
    OP_JNC = 3'd6,
    OP_JMP = 3'd7
  } op_t;

  state_t state;
  state_t state_n;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] ir;
  logic [WORD_W-1:0] md;
  logic [ADDR_W-1:0] ma;

  op_t               op;
  logic [ADDR_W-1:0] ir_a;
  logic [WORD_W:0]   sum;
  logic [WORD_W-1:0] diff;
  logic              take;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [WORD_W-1:0] mem_wd;

  assign op       = op_t'(ir[WORD_W-1 -: 3]);
  assign ir_a     = ir[ADDR_W-1:0];
  assign sum      = {1'b0, ac} + {1'b0, md};
  assign diff     = ac - md;
  assign dbg_data = mem[dbg_addr];

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // next state, branch decision and RAM write port select
  always_comb begin
    state_n = state;
    take    = 1'b0;
    mem_we  = 1'b0;
    mem_wa  = ma;
    mem_wd  = md;
    unique case (state)
      IDLE: begin
        if (load_en) begin
          mem_we = 1'b1;
          mem_wa = load_addr;
          mem_wd = load_data;
        end
        if (start) state_n = F1;
      end
      F1: state_n = F2;
      F2: state_n = F3;
      F3: state_n = E1;
      E1: begin
        unique case (op)
          OP_HLT: state_n = IDLE;
          OP_JNZ: begin
            take    = !zf;
            state_n = F1;
          end
          OP_JNC: begin
            take    = !cf;
            state_n = F1;
          end
          OP_JMP: begin
            take    = 1'b1;
            state_n = F1;
          end
          default: state_n = E2;
        endcase
      end
      E2: begin
        state_n = F1;
        mem_we  = (op == OP_STO);
      end
      default: state_n = IDLE;
    endcase
  end

  // RAM write port: contents survive reset
  always_ff @(posedge clock) begin
    if (mem_we && !reset) mem[mem_wa] <= mem_wd;
  end

  // datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc       <= '0;
      ir       <= '0;
      ma       <= '0;
      md       <= '0;
      ac       <= '0;
      out_port <= '0;
      cf       <= 1'b0;
      zf       <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            pc     <= '0;
            ac     <= '0;
            cf     <= 1'b0;
            zf     <= 1'b0;
            halted <= 1'b0;
            busy   <= 1'b1;
          end
        end
        F1: ma <= pc;
        F2: md <= mem[ma];
        F3: begin
          ir <= md;
          ma <= md[ADDR_W-1:0];
          pc <= pc + ADDR_W'(1);
        end
        E1: begin
          unique case (op)
            OP_LDA, OP_ADD, OP_SUB: md <= mem[ma];
            OP_STO: md <= ac;
            OP_HLT: begin
              halted <= 1'b1;
              busy   <= 1'b0;
            end
            default: if (take) pc <= ir_a;
          endcase
        end
        E2: begin
          unique case (op)
            OP_LDA: begin
              ac <= md;
              zf <= (md == '0);
            end
            OP_ADD: begin
              {cf, ac} <= sum;
              zf       <= (sum[WORD_W-1:0] == '0);
            end
            OP_SUB: begin
              ac <= diff;
              cf <= (md > ac);
              zf <= (diff == '0);
            end
            OP_STO: if (ma == OUT_A) out_port <= md;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu_param.sv
// tb_acc_cpu_param: scenario tasks with final-state and out_port scoreboards.
// Covers default (ADDR_W=5) and wide (ADDR_W=6) instances.
module tb_acc_cpu_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       load_en, start;
  logic [4:0] load_addr, dbg_addr, pc;
  logic [7:0] load_data, ac, out_port, dbg_data;
  logic       busy, halted, cf, zf;

  logic       load_en6, start6;
  logic [5:0] load_addr6, dbg_addr6, pc6;
  logic [8:0] load_data6, ac6, out6, dbg_data6;
  logic       busy6, halted6, cf6, zf6;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] ac;
    logic       cf;
    logic       zf;
    logic [4:0] pc;
    int         edges;
  } res_t;

  res_t       res_q[$];
  logic [7:0] out_q[$];
  logic [8:0] out6_q[$];

  always #5 clock = ~clock;

  acc_cpu_param u5 (
    .clock(clock), .reset(reset),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .busy(busy), .halted(halted),
    .pc(pc), .ac(ac), .cf(cf), .zf(zf), .out_port(out_port),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  acc_cpu_param #(.ADDR_W(6)) u6 (
    .clock(clock), .reset(reset),
    .load_en(load_en6), .load_addr(load_addr6), .load_data(load_data6),
    .start(start6), .busy(busy6), .halted(halted6),
    .pc(pc6), .ac(ac6), .cf(cf6), .zf(zf6), .out_port(out6),
    .dbg_addr(dbg_addr6), .dbg_data(dbg_data6)
  );

  task automatic load(input logic [4:0] a, input logic [7:0] d);
    @(negedge clock);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  task automatic load6(input logic [5:0] a, input logic [8:0] d);
    @(negedge clock);
    load_en6 = 1'b1; load_addr6 = a; load_data6 = d;
    @(negedge clock);
    load_en6 = 1'b0;
  endtask

  // Start u5, optionally load in the start cycle and disturb it mid-run,
  // pop out_port expectations as stores appear, wait for halt.
  task automatic run(input int max, input int dis_at, input bit sl,
                     input logic [4:0] sa, input logic [7:0] sd,
                     output int edges);
    int n;
    logic [7:0] last, w;
    last  = out_port;
    n     = 0;
    edges = -1;
    @(negedge clock);
    start = 1'b1;
    if (sl) begin
      load_en = 1'b1; load_addr = sa; load_data = sd;
    end
    while (n < max) begin
      @(posedge clock);
      n++;
      #1;
      start   = 1'b0;
      load_en = 1'b0;
      if (n == dis_at) begin
        start = 1'b1; load_en = 1'b1;
        load_addr = 5'd0; load_data = 8'hFF;
      end
      if (out_port !== last) begin
        last = out_port;
        checks++;
        if (out_q.size() == 0) begin
          errors++;
          $display("FAIL out_port unexpected store got %0h", out_port);
        end else begin
          w = out_q.pop_front();
          if (out_port !== w) begin
            errors++;
            $display("FAIL out_port got %0h want %0h", out_port, w);
          end
        end
      end
      if (halted === 1'b1) begin
        edges = n;
        break;
      end
    end
    start   = 1'b0;
    load_en = 1'b0;
    checks++;
    if (edges < 0) begin
      errors++;
      $display("FAIL halt_timeout got no halt want halt within %0d", max);
    end
    checks++;
    if (out_q.size() != 0) begin
      errors++;
      $display("FAIL out_port_missing got %0d pending want 0", out_q.size());
    end
    out_q.delete();
  endtask

  task automatic test_reset_state();
    checks++;
    if ({pc, ac, cf, zf, busy, halted, out_port} !== '0) begin
      errors++;
      $display("FAIL reset_state pc=%0h ac=%0h cf=%0b zf=%0b busy=%0b halted=%0b out=%0h want all 0",
               pc, ac, cf, zf, busy, halted, out_port);
    end
    checks++;
    if ({pc6, ac6, cf6, zf6, busy6, halted6, out6} !== '0) begin
      errors++;
      $display("FAIL reset_state6 pc=%0h ac=%0h out=%0h want all 0", pc6, ac6, out6);
    end
  endtask

  task automatic test_basic();
    res_t e;
    int n;
    load(5'd0, 8'h24); load(5'd1, 8'h45);
    load(5'd2, 8'h66); load(5'd3, 8'h00);
    load(5'd4, 8'h03); load(5'd5, 8'h02);
    res_q.push_back('{ac: 8'h05, cf: 1'b0, zf: 1'b0, pc: 5'd4, edges: 20});
    run(200, 0, 1'b0, 5'd0, 8'h00, n);
    e = res_q.pop_front();
    checks++;
    if ({ac, cf, zf, pc, busy} !== {e.ac, e.cf, e.zf, e.pc, 1'b0}) begin
      errors++;
      $display("FAIL basic_state ac=%0h cf=%0b zf=%0b pc=%0h busy=%0b want ac=%0h cf=%0b zf=%0b pc=%0h busy=0",
               ac, cf, zf, pc, busy, e.ac, e.cf, e.zf, e.pc);
    end
    checks++;
    if (n !== e.edges) begin
      errors++;
      $display("FAIL basic_cycles got %0d want %0d", n, e.edges);
    end
    dbg_addr = 5'd6;
    #1;
    checks++;
    if (dbg_data !== 8'h05) begin
      errors++;
      $display("FAIL basic_ram6 got %0h want 05", dbg_data);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    checks++;
    if (ac !== 8'h03) begin
      errors++;
      $display("FAIL reset_pre_ac got %0h want 03", ac);
    end
    #2 reset = 1'b1;
    dbg_addr = 5'd4;
    #1;
    checks++;
    if ({pc, ac, cf, zf, busy, halted, out_port} !== '0) begin
      errors++;
      $display("FAIL reset_async pc=%0h ac=%0h busy=%0b halted=%0b want 0",
               pc, ac, busy, halted);
    end
    checks++;
    if (dbg_data !== 8'h03) begin
      errors++;
      $display("FAIL reset_ram4 got %0h want 03", dbg_data);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({ac, pc, busy} !== '0) begin
      errors++;
      $display("FAIL reset_abort ac=%0h pc=%0h busy=%0b want 0", ac, pc, busy);
    end
  endtask

  task automatic test_carry();
    res_t e;
    int n;
    load(5'd0, 8'h24); load(5'd1, 8'h45);
    load(5'd2, 8'hD0); load(5'd3, 8'h00);
    load(5'd4, 8'hFF); load(5'd5, 8'h01);
    load(5'd16, 8'h00);
    res_q.push_back('{ac: 8'h00, cf: 1'b1, zf: 1'b1, pc: 5'd4, edges: 19});
    run(200, 0, 1'b0, 5'd0, 8'h00, n);
    e = res_q.pop_front();
    checks++;
    if ({ac, cf, zf, pc, busy} !== {e.ac, e.cf, e.zf, e.pc, 1'b0}) begin
      errors++;
      $display("FAIL carry_state ac=%0h cf=%0b zf=%0b pc=%0h want ac=%0h cf=%0b zf=%0b pc=%0h",
               ac, cf, zf, pc, e.ac, e.cf, e.zf, e.pc);
    end
    checks++;
    if (n !== e.edges) begin
      errors++;
      $display("FAIL carry_cycles got %0d want %0d", n, e.edges);
    end
  endtask

  task automatic test_borrow();
    res_t e;
    int n;
    load(5'd0, 8'h24); load(5'd1, 8'h85);
    load(5'd2, 8'hA8); load(5'd3, 8'h00);
    load(5'd4, 8'h02); load(5'd5, 8'h03);
    load(5'd8, 8'h00);
    res_q.push_back('{ac: 8'hFF, cf: 1'b1, zf: 1'b0, pc: 5'd9, edges: 19});
    run(200, 0, 1'b0, 5'd0, 8'h00, n);
    e = res_q.pop_front();
    checks++;
    if ({ac, cf, zf, pc, busy} !== {e.ac, e.cf, e.zf, e.pc, 1'b0}) begin
      errors++;
      $display("FAIL borrow_state ac=%0h cf=%0b zf=%0b pc=%0h want ac=%0h cf=%0b zf=%0b pc=%0h",
               ac, cf, zf, pc, e.ac, e.cf, e.zf, e.pc);
    end
    checks++;
    if (n !== e.edges) begin
      errors++;
      $display("FAIL borrow_cycles got %0d want %0d", n, e.edges);
    end
  endtask

  // countdown loop; word 0 is written in the same cycle as start
  task automatic countdown(input string tag, input bit sl, input int dis_at);
    res_t e;
    int n;
    res_q.push_back('{ac: 8'h00, cf: 1'b0, zf: 1'b1, pc: 5'd5, edges: 52});
    out_q.push_back(8'h02);
    out_q.push_back(8'h01);
    out_q.push_back(8'h00);
    run(400, dis_at, sl, 5'd0, 8'h34, n);
    e = res_q.pop_front();
    checks++;
    if ({ac, cf, zf, pc, busy} !== {e.ac, e.cf, e.zf, e.pc, 1'b0}) begin
      errors++;
      $display("FAIL %s_state ac=%0h cf=%0b zf=%0b pc=%0h want ac=%0h cf=%0b zf=%0b pc=%0h",
               tag, ac, cf, zf, pc, e.ac, e.cf, e.zf, e.pc);
    end
    checks++;
    if (n !== e.edges) begin
      errors++;
      $display("FAIL %s_cycles got %0d want %0d", tag, n, e.edges);
    end
    dbg_addr = 5'd0;
    #1;
    checks++;
    if (dbg_data !== 8'h34) begin
      errors++;
      $display("FAIL %s_ram0 got %0h want 34", tag, dbg_data);
    end
  endtask

  task automatic test_countdown();
    load(5'd1, 8'h95); load(5'd2, 8'h7F);
    load(5'd3, 8'hA1); load(5'd4, 8'h00);
    load(5'd20, 8'h03); load(5'd21, 8'h01);
    countdown("countdown", 1'b1, 0);
  endtask

  task automatic test_busy_lockout();
    countdown("lockout", 1'b0, 10);
  endtask

  task automatic test_restart();
    @(negedge clock);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL restart_pre_halted got %0b want 1", halted);
    end
    countdown("restart", 1'b0, 0);
  endtask

  task automatic test_param();
    int n, edges;
    logic [8:0] last, w;
    load6(6'd0, 9'h061); load6(6'd1, 9'h0FF);
    load6(6'd2, 9'h0A2); load6(6'd3, 9'h000);
    load6(6'd33, 9'h1FF); load6(6'd34, 9'h001);
    out6_q.push_back(9'h1FF);
    n     = 0;
    edges = -1;
    last  = out6;
    @(negedge clock);
    start6 = 1'b1;
    while (n < 200) begin
      @(posedge clock);
      n++;
      #1;
      start6 = 1'b0;
      if (out6 !== last) begin
        last = out6;
        checks++;
        if (out6_q.size() == 0) begin
          errors++;
          $display("FAIL param_out unexpected store got %0h", out6);
        end else begin
          w = out6_q.pop_front();
          if (out6 !== w) begin
            errors++;
            $display("FAIL param_out got %0h want %0h", out6, w);
          end
        end
      end
      if (halted6 === 1'b1) begin
        edges = n;
        break;
      end
    end
    start6 = 1'b0;
    checks++;
    if (edges !== 20) begin
      errors++;
      $display("FAIL param_cycles got %0d want 20", edges);
    end
    checks++;
    if ({ac6, cf6, zf6, pc6, busy6} !== {9'h000, 1'b1, 1'b1, 6'd4, 1'b0}) begin
      errors++;
      $display("FAIL param_state ac=%0h cf=%0b zf=%0b pc=%0h want ac=0 cf=1 zf=1 pc=4",
               ac6, cf6, zf6, pc6);
    end
    checks++;
    if (out6_q.size() != 0) begin
      errors++;
      $display("FAIL param_out_missing got %0d pending want 0", out6_q.size());
    end
    dbg_addr6 = 6'd63;
    #1;
    checks++;
    if (dbg_data6 !== 9'h1FF) begin
      errors++;
      $display("FAIL param_ram63 got %0h want 1ff", dbg_data6);
    end
  endtask

  initial begin
    reset = 1'b1;
    load_en = 1'b0; start = 1'b0;
    load_addr = '0; load_data = '0; dbg_addr = '0;
    load_en6 = 1'b0; start6 = 1'b0;
    load_addr6 = '0; load_data6 = '0; dbg_addr6 = '0;
    #3;
    test_reset_state();
    @(negedge clock);
    reset = 1'b0;
    test_basic();
    test_reset();
    test_carry();
    test_borrow();
    test_countdown();
    test_busy_lockout();
    test_restart();
    test_param();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_cpu_param.md
Name: acc_cpu_param

Overview:
- Parametrised, synthesizable successor of the team's 8-bit accumulator CPU: the same 3-bit-opcode + address instruction format, generalised in address width, with a real clock/reset interface.
- Internal unified program/data RAM, loaded through a write port; a start/halted handshake; a memory-mapped output register.
- Corrected flag semantics: two's-complement carry/borrow; JNZ/JNC jump on flag clear.
- Sits under the course testbench as the reusable CPU core.

Parameters:
- ADDR_W, 5, address bits; RAM depth = 2**ADDR_W words.
- WORD_W, 3+ADDR_W (derived, not overridable), instruction/data word width.
- OUT_ADDR, 2**ADDR_W-1, RAM address whose STO also updates out_port.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all registers except RAM.
- load_en  in  1  RAM write strobe; honoured only when busy=0.
- load_addr  in  ADDR_W  RAM write address.
- load_data  in  WORD_W  RAM write data.
- start  in  1  begin execution at PC=0; honoured only when busy=0.
- busy  out  1  high from the edge that accepts start until halt.
- halted  out  1  high after HLT executes; cleared by start or reset.
- pc  out  ADDR_W  program counter.
- ac  out  WORD_W  accumulator.
- cf  out  1  carry/borrow flag.
- zf  out  1  zero flag.
- out_port  out  WORD_W  last value stored to OUT_ADDR.
- dbg_addr  in  ADDR_W  RAM debug read address.
- dbg_data  out  WORD_W  combinational RAM[dbg_addr].

Behaviour:
- Reset: state=IDLE; pc, ir, ma, md, ac, out_port = 0; cf, zf, busy, halted = 0. RAM contents are not altered. Reset mid-instruction aborts it; a partially executed STO does not write.
- Opcodes (IR[WORD_W-1:WORD_W-3]), address a = IR[ADDR_W-1:0]:
  - 000 HLT
  - 001 LDA: ac=RAM[a]; zf updated; cf unchanged.
  - 010 ADD: {cf,ac}=ac+RAM[a] at WORD_W+1 bits.
  - 011 STO: RAM[a]=ac; flags unchanged.
  - 100 SUB: ac=ac-RAM[a] mod 2**WORD_W; cf=1 iff RAM[a]>ac (unsigned borrow).
  - 101 JNZ: pc=a if zf==0.
  - 110 JNC: pc=a if cf==0.
  - 111 JMP: pc=a.
  - zf = (new ac == 0) for LDA, ADD and SUB.
- FSM, one state per clock:
  - IDLE: start → F1 with pc=0, ac=0, cf=0, zf=0, halted=0, busy=1.
  - F1: ma<=pc.
  - F2: md<=RAM[ma].
  - F3: ir<=md, ma<=md[ADDR_W-1:0], pc<=pc+1 (wraps 2**ADDR_W-1 → 0).
  - E1: LDA/ADD/SUB md<=RAM[ma]; STO md<=ac; JNZ/JNC/JMP resolve pc and → F1; HLT sets halted=1, busy=0 and → IDLE.
  - E2: LDA/ADD/SUB update ac and flags; STO writes RAM[ma]=md and out_port if ma==OUT_ADDR; → F1.
- Cycle counts: LDA/ADD/SUB/STO 5 cycles; JNZ/JNC/JMP/HLT 4 cycles.
- Simultaneous events:
  - load_en and start together in IDLE: the write happens, then execution starts, and the first fetch sees the new data.
  - load_en or start while busy: ignored, no effect.
  - STO targeting the currently executing or next instruction word: self-modification takes effect at the next F2 of that address.
- dbg_data is combinational, independent of state.

Test Plan:
- Reset: assert reset asynchronously mid-ADD → all outputs 0 immediately; RAM[4] still holds its loaded value via dbg_data.
- Load program 00=0x24 (LDA 4), 01=0x45 (ADD 5), 02=0x66 (STO 6), 03=0x00 (HLT), RAM[4]=3, RAM[5]=2; pulse start.
  - halted rises on the 20th edge counting the start edge.
  - ac=5, cf=0, zf=0, RAM[6]=5, pc=4, busy=0.
- Carry: RAM[4]=0xFF, RAM[5]=0x01, program LDA 4, ADD 5, JNC 0x10, HLT.
  - Expect ac=0x00, cf=1, zf=1; jump not taken; halts with pc=4.
- Borrow: LDA of 0x02, then SUB of 0x03 → ac=0xFF, cf=1, zf=0.
  - A following JNZ to 0x08 is taken: pc=0x08.
- Countdown loop with counter=3: SUB constant 1, STO 31 (OUT_ADDR), JNZ back, HLT.
  - out_port sequence 2, 1, 0; halts with zf=1.
- Busy lockout: during a run, issue load_en to addr 0 with 0xFF and pulse start → RAM[0] unchanged and execution undisturbed.
- Restart after halt: start → halted clears and the program reruns from pc=0.
- Parameter check: ADDR_W=6 (WORD_W=9); LDA 33, ADD 34 with 0x1FF+0x001 → ac=0, cf=1; STO 63 updates out_port.
